imem_port_arbiter: RTL and testbench

- Shares the single instruction-memory port (InstructionMemory / Memory32 array) between the core fetch path and the boot-loader / debug port.
- Arbitrates each cycle, drives the memory address, write enable and write data, and routes read data back to the granted requester one cycle later.
- Sits between the PC/fetch stage, the loader, and the instruction memory.

---
 rtl/imem_arb_pkg.sv | 15 +
 rtl/imem_port_arbiter_if.sv | 48 ++++
 rtl/imem_arb_starve_ctr.sv | 30 +++
 rtl/imem_port_arbiter.sv | 100 ++++++++++
 tb/tb_imem_port_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// Optional perf counters in the top are enabled with IMEM_ARB_PERF_EN.
package imem_arb_pkg;

  localparam int ADDR_W_DEF   = 9;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between fetch path, loader, arbiter and instruction memory.
// slave = arbiter side, master = requesters/memory side.
interface imem_port_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive denied loader cycles; at_max forces a loader grant.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_q <= cnt_q + STARVE_CNT_W'(1);
    end
  end

  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between fetch and the loader/debug port.
// Define IMEM_ARB_PERF_EN to build the fetch grant/stall counters; otherwise they read 0.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_port_arbiter_if.slave  bus,
  output logic [31:0]         perf_fetch_gnt_cnt,
  output logic [31:0]         perf_fetch_stall_cnt
);

  logic              at_max;
  logic              fetch_gnt;
  logic              ld_gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] fetch_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;
  owner_e            owner_q;
  owner_e            owner_d;

  // Grants are gated by rst_n so nothing reaches the memory while reset is held.
  assign ld_gnt    = rst_n & bus.ld_req &
                     (bus.ld_lock | at_max | ~bus.fetch_req);
  assign fetch_gnt = rst_n & bus.fetch_req & ~bus.ld_lock &
                     ~(at_max & bus.ld_req);

  imem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (bus.ld_req & ~ld_gnt),
    .clr    (ld_gnt | ~bus.ld_req),
    .at_max (at_max)
  );

  always_comb begin
    bus.mem_addr  = addr_q;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    owner_d       = OWN_NONE;
    if (ld_gnt) begin
      bus.mem_addr = bus.ld_addr;
      if (bus.ld_we) begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.ld_wdata;
      end else begin
        owner_d = OWN_LOAD;
      end
    end else if (fetch_gnt) begin
      bus.mem_addr = bus.fetch_addr;
      owner_d      = OWN_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      owner_q       <= OWN_NONE;
      fetch_rdata_q <= '0;
      ld_rdata_q    <= '0;
    end else begin
      addr_q  <= bus.mem_addr;
      owner_q <= owner_d;
      if (owner_q == OWN_FETCH) fetch_rdata_q <= bus.mem_rdata;
      if (owner_q == OWN_LOAD)  ld_rdata_q    <= bus.mem_rdata;
    end
  end

  // Memory read data arrives the cycle after the grant; the idle side keeps its last word.
  assign bus.fetch_gnt    = fetch_gnt;
  assign bus.ld_gnt       = ld_gnt;
  assign bus.fetch_rvalid = (owner_q == OWN_FETCH);
  assign bus.ld_rvalid    = (owner_q == OWN_LOAD);
  assign bus.fetch_rdata  = (owner_q == OWN_FETCH) ? bus.mem_rdata : fetch_rdata_q;
  assign bus.ld_rdata     = (owner_q == OWN_LOAD)  ? bus.mem_rdata : ld_rdata_q;

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_gnt_cnt   <= '0;
      perf_fetch_stall_cnt <= '0;
    end else begin
      if (fetch_gnt && (perf_fetch_gnt_cnt != 32'hFFFF_FFFF))
        perf_fetch_gnt_cnt <= perf_fetch_gnt_cnt + 32'd1;
      if (bus.fetch_req && !fetch_gnt && (perf_fetch_stall_cnt != 32'hFFFF_FFFF))
        perf_fetch_stall_cnt <= perf_fetch_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_gnt_cnt   = 32'd0;
  assign perf_fetch_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a synchronous-read memory model.
// Perf counter expectations follow IMEM_ARB_PERF_EN.
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  typedef struct {
    owner_e      own;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] perf_gnt;
  logic [31:0] perf_stall;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  rsp_t        sb [$];
  logic [31:0] hold_f;
  logic [31:0] hold_l;

  imem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  imem_port_arbiter #(
    .ADDR_W     (9),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus),
    .perf_fetch_gnt_cnt   (perf_gnt),
    .perf_fetch_stall_cnt (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the response due this cycle, then queue the one implied by this cycle's grant.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      sb.delete();
      hold_f = '0;
      hold_l = '0;
    end else begin
      chk("one_gnt", bus.fetch_gnt & bus.ld_gnt, 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.own == OWN_FETCH) begin
          chk("f_rvalid", bus.fetch_rvalid, 1);
          chk("f_rdata", bus.fetch_rdata, e.data);
          chk("l_rvalid_idle", bus.ld_rvalid, 0);
          chk("l_rdata_hold", bus.ld_rdata, hold_l);
          hold_f = e.data;
        end else begin
          chk("l_rvalid", bus.ld_rvalid, 1);
          chk("l_rdata", bus.ld_rdata, e.data);
          chk("f_rvalid_idle", bus.fetch_rvalid, 0);
          chk("f_rdata_hold", bus.fetch_rdata, hold_f);
          hold_l = e.data;
        end
      end else begin
        chk("f_rvalid_none", bus.fetch_rvalid, 0);
        chk("l_rvalid_none", bus.ld_rvalid, 0);
      end
      if (bus.fetch_gnt)
        sb.push_back('{OWN_FETCH, ref_mem[bus.fetch_addr]});
      else if (bus.ld_gnt && !bus.ld_we)
        sb.push_back('{OWN_LOAD, ref_mem[bus.ld_addr]});
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    mem[0] = 32'h0050_0093;  ref_mem[0] = 32'h0050_0093;
    mem[4] = 32'h0010_0113;  ref_mem[4] = 32'h0010_0113;
    mem[8] = 32'h0020_81B3;  ref_mem[8] = 32'h0020_81B3;

    rst_n          = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 9'h000;
    bus.ld_req     = 1'b0;
    bus.ld_we      = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_wdata   = '0;
    bus.ld_lock    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_f_gnt", bus.fetch_gnt, 0);
    chk("rst_f_rvalid", bus.fetch_rvalid, 0);
    chk("rst_l_rvalid", bus.ld_rvalid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);

    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_f_gnt", bus.fetch_gnt, 1);
    chk("rel_mem_addr", bus.mem_addr, 9'h000);

    for (int a = 4; a <= 8; a += 4) begin
      step();
      bus.fetch_addr = 9'(a);
      @(negedge clk);
      chk("stream_gnt", bus.fetch_gnt, 1);
      chk("stream_addr", bus.mem_addr, a);
    end

    step();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("idle_gnt", bus.fetch_gnt, 0);
    chk("addr_hold", bus.mem_addr, 9'h008);
    chk("idle_we", bus.mem_we, 0);

    // Both requesters held: loader forced in every fifth cycle.
    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 9'h00C;
    bus.ld_req     = 1'b1;
    bus.ld_we      = 1'b0;
    bus.ld_addr    = 9'h020;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("cont_f_gnt", bus.fetch_gnt, (i % 5) != 4);
      chk("cont_l_gnt", bus.ld_gnt, (i % 5) == 4);
      chk("cont_addr", bus.mem_addr, ((i % 5) == 4) ? 9'h020 : 9'h00C);
    end

    step();
    bus.fetch_req = 1'b0;
    bus.ld_req    = 1'b0;
    @(negedge clk);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_gnt", perf_gnt, 11);
    chk("perf_stall", perf_stall, 2);
`else
    chk("perf_gnt_off", perf_gnt, 0);
    chk("perf_stall_off", perf_stall, 0);
`endif

    step();
    bus.ld_lock    = 1'b1;
    bus.ld_req     = 1'b1;
    bus.ld_we      = 1'b1;
    bus.ld_addr    = 9'h010;
    bus.ld_wdata   = 32'hDEAD_BEEF;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 9'h030;
    ref_mem[16]    = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lk_w_l_gnt", bus.ld_gnt, 1);
    chk("lk_w_f_gnt", bus.fetch_gnt, 0);
    chk("lk_w_we", bus.mem_we, 1);
    chk("lk_w_addr", bus.mem_addr, 9'h010);
    chk("lk_w_wdata", bus.mem_wdata, 32'hDEAD_BEEF);

    step();
    bus.ld_we = 1'b0;
    @(negedge clk);
    chk("lk_r_l_gnt", bus.ld_gnt, 1);
    chk("lk_r_f_gnt", bus.fetch_gnt, 0);
    chk("lk_r_we", bus.mem_we, 0);
    chk("lk_w_no_rvalid", bus.ld_rvalid, 0);

    step();
    bus.ld_req    = 1'b0;
    bus.ld_lock   = 1'b0;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("lk_r_rvalid", bus.ld_rvalid, 1);
    chk("lk_r_rdata", bus.ld_rdata, 32'hDEAD_BEEF);
    chk("lk_f_rdata_hold", bus.fetch_rdata, 32'hA500_000C);

    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 9'h004;
    @(negedge clk);
    chk("mf_gnt", bus.fetch_gnt, 1);
    step();
    bus.ld_lock = 1'b1;
    @(negedge clk);
    chk("mf_gnt_locked", bus.fetch_gnt, 0);
    chk("mf_rvalid", bus.fetch_rvalid, 1);
    chk("mf_rdata", bus.fetch_rdata, 32'h0010_0113);

    step();
    bus.ld_lock    = 1'b0;
    bus.fetch_addr = 9'h008;
    @(negedge clk);
    chk("rmid_gnt", bus.fetch_gnt, 1);
    #1;
    rst_n         = 1'b0;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("rmid_rvalid", bus.fetch_rvalid, 0);
    chk("rmid_rdata", bus.fetch_rdata, 0);
    chk("rmid_addr", bus.mem_addr, 0);

    step();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
